// File: rtl/ext16_arbiter.sv
// Two-requester arbiter sharing one 16-to-32 sign/zero extender, feeding a
// one-entry registered output slot with valid/ready handshakes on both sides.
module ext16_arbiter #(
  parameter bit RR = 1'b1  // 1: round-robin, 0: requester 0 always wins
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  input  logic [15:0] r0_x,
  input  logic        r0_b,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [15:0] r1_x,
  input  logic        r1_b,
  output logic        r1_ready,
  output logic        out_valid,
  output logic [31:0] out_y,
  output logic        out_id,
  input  logic        out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] y_q;
  logic        id_q;

  logic        slot_free;
  logic        gnt0, gnt1;
  logic        accept;
  logic        sel_id;
  logic [15:0] sel_x;
  logic        sel_b;
  logic [31:0] ext_y;

  assign out_valid = (state_q == FULL);
  assign out_y     = y_q;
  assign out_id    = id_q;

  // A full slot can still take a new result when it is being drained this cycle.
  assign slot_free = !out_valid || out_ready;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (r0_valid && r1_valid) begin
      if (RR && !last_q) gnt1 = 1'b1;
      else               gnt0 = 1'b1;
    end else begin
      gnt0 = r0_valid;
      gnt1 = r1_valid;
    end
  end

  // Gating with rst_n keeps both readies low during reset without waiting for a clock.
  assign r0_ready = rst_n && slot_free && gnt0;
  assign r1_ready = rst_n && slot_free && gnt1;
  assign accept   = r0_ready || r1_ready;

  assign sel_id = r1_ready;
  assign sel_x  = sel_id ? r1_x : r0_x;
  assign sel_b  = sel_id ? r1_b : r0_b;
  assign ext_y  = {{16{sel_b & sel_x[15]}}, sel_x};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) last_d = sel_id;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;  // requester 0 wins the first contended grant
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // NOTE: the result payload is reset too, because out_y must read zero while
  // reset is held, not just be ignored behind out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q  <= 32'h0;
      id_q <= 1'b0;
    end else if (accept) begin
      y_q  <= ext_y;
      id_q <= sel_id;
    end
  end

endmodule

// File: tb/tb_ext16_arbiter.sv
// Bench for ext16_arbiter: a round-robin and a fixed-priority instance share
// stimulus; a per-cycle model compare plus directed literal checks.
module tb_ext16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_b, r1_valid, r1_b, out_ready;
  logic [15:0] r0_x, r1_x;

  // index 0: RR=1 instance, index 1: RR=0 instance
  logic [1:0]  rdy0, rdy1, ov, oid;
  logic [31:0] oy [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ext16_arbiter #(.RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_x(r0_x), .r0_b(r0_b), .r0_ready(rdy0[0]),
    .r1_valid(r1_valid), .r1_x(r1_x), .r1_b(r1_b), .r1_ready(rdy1[0]),
    .out_valid(ov[0]), .out_y(oy[0]), .out_id(oid[0]), .out_ready(out_ready)
  );

  ext16_arbiter #(.RR(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_x(r0_x), .r0_b(r0_b), .r0_ready(rdy0[1]),
    .r1_valid(r1_valid), .r1_x(r1_x), .r1_b(r1_b), .r1_ready(rdy1[1]),
    .out_valid(ov[1]), .out_y(oy[1]), .out_id(oid[1]), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid [2];
  logic [31:0] m_y     [2];
  logic        m_id    [2];
  logic        m_last  [2];  // requester granted most recently

  function automatic logic [31:0] extend(input logic [15:0] x, input logic b);
    return b ? 32'($signed(x)) : {16'h0000, x};
  endfunction

  // Requester that would win given who is asking; -1 if nobody asks.
  function automatic int winner(input int k);
    if (r0_valid && r1_valid) return (k == 0 && m_last[k] == 1'b0) ? 1 : 0;
    if (r0_valid) return 0;
    if (r1_valid) return 1;
    return -1;
  endfunction

  function automatic bit m_slot(input int k);
    return rst_n && (!m_valid[k] || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] <= 1'b0;
        m_y[k]     <= 32'h0;
        m_id[k]    <= 1'b0;
        m_last[k]  <= 1'b1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int w;
        w = winner(k);
        if (m_slot(k) && w >= 0) begin
          m_valid[k] <= 1'b1;
          m_y[k]     <= (w == 1) ? extend(r1_x, r1_b) : extend(r0_x, r0_b);
          m_id[k]    <= (w == 1);
          m_last[k]  <= (w == 1);
        end else if (out_ready) begin
          m_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Compare process: inputs change just after posedge, so negedge is stable.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w;
      w = winner(k);
      check($sformatf("mdl_r0_ready[%0d]", k), 32'(rdy0[k]), 32'(m_slot(k) && w == 0));
      check($sformatf("mdl_r1_ready[%0d]", k), 32'(rdy1[k]), 32'(m_slot(k) && w == 1));
      check($sformatf("mdl_out_valid[%0d]", k), 32'(ov[k]), 32'(m_valid[k]));
      check($sformatf("mdl_out_y[%0d]", k), oy[k], m_y[k]);
      check($sformatf("mdl_out_id[%0d]", k), 32'(oid[k]), 32'(m_id[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic v0, input logic [15:0] x0, input logic b0,
                        input logic v1, input logic [15:0] x1, input logic b1,
                        input logic ordy);
    r0_valid = v0; r0_x = x0; r0_b = b0;
    r1_valid = v1; r1_x = x1; r1_b = b1;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0;
    set_in(1'b1, 16'h1234, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b1);
    #1;
    check("rst_r0_ready", 32'(rdy0[0]), 32'h0);
    check("rst_r1_ready", 32'(rdy1[0]), 32'h0);
    tick(); tick();
    check("rst_out_valid", 32'(ov[0]), 32'h0);
    check("rst_out_y", oy[0], 32'h0);
    check("rst_out_id", 32'(oid[0]), 32'h0);
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();

    // r0 alone, sign-extend a negative operand
    set_in(1'b1, 16'h8000, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    #1 check("r0only_ready", 32'(rdy0[0]), 32'h1);
    tick();
    check("r0only_valid", 32'(ov[0]), 32'h1);
    check("r0only_y", oy[0], 32'hFFFF8000);
    check("r0only_id", 32'(oid[0]), 32'h0);

    // r1 alone, zero-extend then sign-extend a positive operand
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    tick();
    check("r1_zext_y", oy[0], 32'h00008000);
    check("r1_zext_id", 32'(oid[0]), 32'h1);
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    tick();
    check("r1_sext_pos_y", oy[0], 32'h00007FFF);
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    check("drain_valid", 32'(ov[0]), 32'h0);

    // both valid, 4 cycles: RR alternates 0,1,0,1; fixed stays on 0
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1);
      #1;
      check($sformatf("rr_onehot_%0d", i), 32'(rdy0[0] + rdy1[0]), 32'h1);
      check($sformatf("fix_r1_ready_%0d", i), 32'(rdy1[1]), 32'h0);
      tick();
      check($sformatf("rr_id_%0d", i), 32'(oid[0]), 32'(i % 2));
      check($sformatf("fix_id_%0d", i), 32'(oid[1]), 32'h0);
    end

    // backpressure: slot FULL, r0 waits 3 cycles, then drain+accept together
    held = oy[0];
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'hABCD, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      #1 check($sformatf("bp_r0_ready_%0d", i), 32'(rdy0[0]), 32'h0);
      tick();
      check($sformatf("bp_y_hold_%0d", i), oy[0], held);
      check($sformatf("bp_valid_%0d", i), 32'(ov[0]), 32'h1);
    end
    set_in(1'b1, 16'hABCD, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    #1 check("bp_release_ready", 32'(rdy0[0]), 32'h1);
    tick();
    check("bp_release_valid", 32'(ov[0]), 32'h1);
    check("bp_release_y", oy[0], 32'hFFFFABCD);
    check("bp_release_id", 32'(oid[0]), 32'h0);

    // asynchronous reset mid-cycle while FULL
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ov[0]), 32'h0);
    check("async_rst_y", oy[0], 32'h0);
    check("async_rst_ready", 32'(rdy0[0]), 32'h0);
    tick();
    rst_n = 1'b1;
    set_in(1'b1, 16'h0011, 1'b0, 1'b1, 16'h0022, 1'b0, 1'b1);
    #1;
    check("post_rst_r0_ready", 32'(rdy0[0]), 32'h1);
    check("post_rst_r1_ready", 32'(rdy1[0]), 32'h0);
    tick();
    check("post_rst_id", 32'(oid[0]), 32'h0);
    check("post_rst_y", oy[0], 32'h00000011);

    // mixed traffic with random backpressure, checked by the model
    for (int i = 0; i < 60; i++) begin
      set_in(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0));
      tick();
    end

    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
